layer_mac_engine: RTL and testbench

Parametrised fully-connected layer engine: sequences one neural-network layer of NUM_OUT neurons over NUM_IN inputs. It generates read addresses for the input SRAM and the weight SRAM and accumulates signed fixed-point products. Each neuron result is shifted, saturated and delivered over a valid/ready handshake. It replaces the hand-driven single-MAC arrangement and sits between the input/weight SRAMs and the next layer's input SRAM or sigma stage.

---
 rtl/layer_mac_pkg.sv | 41 ++++
 rtl/layer_mac_engine_mac_acc.sv | 44 ++++
 rtl/layer_mac_engine.sv | 117 +++++++++++
 tb/tb_layer_mac_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_mac_pkg.sv
// rtl/layer_mac_pkg.sv - shared state type, default widths and shift/saturate helper for layer_mac_engine
package layer_mac_pkg;

   localparam int DEFAULT_DATA_W = 16;
   localparam int DEFAULT_FRAC_W = 8;
   // Widest accumulator the helper can carry; callers zero-extend into this container
   localparam int SAT_MAX_W      = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Sign-extend an acc_w-bit value, floor-shift right by frac_w, clamp to signed data_w range
   function automatic logic signed [SAT_MAX_W-1:0] sat_shift(
      input logic [SAT_MAX_W-1:0] raw,
      input int                   acc_w,
      input int                   data_w,
      input int                   frac_w
   );
      logic signed [SAT_MAX_W-1:0] ext;
      logic signed [SAT_MAX_W-1:0] sh;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      for (int b = 0; b < SAT_MAX_W; b++) begin
         ext[b] = (b < acc_w) ? raw[b] : raw[acc_w-1];
         hi[b]  = (b < data_w - 1);
      end
      lo = ~hi;
      sh = ext >>> frac_w;
      if (sh > hi)
         return hi;
      else if (sh < lo)
         return lo;
      else
         return sh;
   endfunction

endpackage

// File: rtl/layer_mac_engine_mac_acc.sv
// rtl/layer_mac_engine_mac_acc.sv - signed MAC accumulator with shift/saturate output; RELU_EN clamps negatives to 0
module mac_acc
   import layer_mac_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int FRAC_W = DEFAULT_FRAC_W,
   parameter int ACC_W  = 2 * DEFAULT_DATA_W + 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic        [DATA_W-1:0] result
);

   localparam int PROD_W = 2 * DATA_W;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;
   logic        [DATA_W-1:0] sat;

   assign prod = PROD_W'(a) * PROD_W'(b);

   // Clear wins over enable so a new neuron never inherits a stray product
   always_ff @(posedge clk) begin
      if (!reset)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end

   assign sat = DATA_W'(sat_shift(SAT_MAX_W'(unsigned'(acc)), ACC_W, DATA_W, FRAC_W));

`ifdef RELU_EN
   assign result = sat[DATA_W-1] ? '0 : sat;
`else
   assign result = sat;
`endif

endmodule

// File: rtl/layer_mac_engine.sv
// rtl/layer_mac_engine.sv - fully-connected layer sequencer: SRAM addressing, MAC, result handshake (RELU_EN optional)
module layer_mac_engine
   import layer_mac_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int FRAC_W  = DEFAULT_FRAC_W,
   parameter int NUM_IN  = 10,
   parameter int NUM_OUT = 10,
   parameter int IN_AW   = $clog2(NUM_IN),
   parameter int W_AW    = $clog2(NUM_IN * NUM_OUT),
   parameter int OUT_IW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [IN_AW-1:0]  in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic [W_AW-1:0]   w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OUT_IW-1:0] out_index,
   output logic              done
);

   localparam int ACC_W = 2 * DATA_W + $clog2(NUM_IN);
   localparam logic [IN_AW-1:0]  LAST_I = IN_AW'(NUM_IN - 1);
   localparam logic [OUT_IW-1:0] LAST_O = OUT_IW'(NUM_OUT - 1);

   state_t state, state_n;
   logic   start_run;
   logic   handshake;
   logic   last_o;
   logic   rd_v;
   logic   acc_clr;

   assign last_o    = (out_index == LAST_O);
   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);
   assign acc_clr   = start_run | (handshake & ~last_o);

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start_run = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n   = RUN;
               start_run = 1'b1;
            end
         end
         RUN: begin
            if (in_addr == LAST_I)
               state_n = DRAIN;
         end
         DRAIN: state_n = OUT;
         OUT: begin
            if (out_ready) begin
               handshake = 1'b1;
               state_n   = last_o ? IDLE : RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // in_addr doubles as the input counter i; w_addr runs contiguously across neurons
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_addr   <= '0;
         w_addr    <= '0;
         out_index <= '0;
         rd_v      <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_v <= (state == RUN);
         done <= handshake & last_o;
         if (start_run) begin
            in_addr   <= '0;
            w_addr    <= '0;
            out_index <= '0;
         end else if (state == RUN && in_addr != LAST_I) begin
            in_addr <= in_addr + IN_AW'(1);
            w_addr  <= w_addr + W_AW'(1);
         end else if (handshake && !last_o) begin
            in_addr   <= '0;
            w_addr    <= w_addr + W_AW'(1);
            out_index <= out_index + OUT_IW'(1);
         end
      end
   end

   mac_acc #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .en     (rd_v),
      .a      (in_data),
      .b      (w_data),
      .result (out_data)
   );

endmodule

// File: tb/tb_layer_mac_engine.sv
// tb/tb_layer_mac_engine.sv - scoreboard bench for layer_mac_engine with NUM_IN=10, NUM_OUT=2
module tb_layer_mac_engine;

   localparam int DATA_W  = 16;
   localparam int NUM_IN  = 10;
   localparam int NUM_OUT = 2;
   localparam int IN_AW   = 4;
   localparam int W_AW    = 5;
   localparam int OUT_IW  = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [IN_AW-1:0]  in_addr;
   logic [DATA_W-1:0] in_data;
   logic [W_AW-1:0]   w_addr;
   logic [DATA_W-1:0] w_data;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [OUT_IW-1:0] out_index;
   logic              done;

   logic [DATA_W-1:0] in_mem [0:15];
   logic [DATA_W-1:0] w_mem  [0:31];

   logic [16:0] exp_q [$];
   int tests = 0;
   int fails = 0;

   layer_mac_engine #(
      .DATA_W  (DATA_W),
      .FRAC_W  (8),
      .NUM_IN  (NUM_IN),
      .NUM_OUT (NUM_OUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got data %h index %0d expected none", out_data, out_index);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[15:0]));
            check("out_index", 32'(out_index), 32'(e[16]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic [15:0] iv, input logic [15:0] w0, input logic [15:0] w1);
      for (int k = 0; k < 16; k++) in_mem[k] = (k < NUM_IN) ? iv : 16'h0;
      for (int k = 0; k < 32; k++) w_mem[k] = (k < NUM_IN) ? w0 : (k < 2 * NUM_IN) ? w1 : 16'h0;
   endtask

   task automatic push(input logic [15:0] d0, input logic [15:0] d1);
      exp_q.push_back({1'b0, d0});
      exp_q.push_back({1'b1, d1});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Ticks until done is seen (bounded), then a few more; reports latency to out_valid and done count
   task automatic wait_done(input string name, output int lat, output int dones);
      int  n;
      bit  seen;
      n = 0; seen = 0; lat = -1; dones = 0;
      while (!seen && n < 300) begin
         if (out_valid && lat < 0) lat = n;
         if (done) begin
            dones++;
            seen = 1;
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
         end else begin
            tick();
            n++;
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done) dones++;
      end
   endtask

   task automatic run_layer(input string name, input bit chk_lat);
      int lat, dones;
      pulse_start();
      wait_done(name, lat, dones);
      if (chk_lat) check({name, "_latency"}, 32'(lat), 32'd11);
      check({name, "_done_count"}, 32'(dones), 32'd1);
   endtask

   initial begin
      int lat, dones, n, busy_cnt;
      logic [15:0] neg_sat, neg_one;
`ifdef RELU_EN
      neg_sat = 16'h0000;
      neg_one = 16'h0000;
`else
      neg_sat = 16'h8000;
      neg_one = 16'hFFFF;
`endif
      reset = 1'b0; start = 1'b0; out_ready = 1'b1;
      set_mem(16'h0100, 16'h0100, 16'h0100);
      repeat (3) tick();
      check("rst_in_addr", 32'(in_addr), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      tick();

      // basic layer
      push(16'h0A00, 16'h0A00);
      run_layer("t1", 1'b1);

      // saturation both directions
      set_mem(16'h7FFF, 16'h7FFF, 16'h7FFF);
      push(16'h7FFF, 16'h7FFF);
      run_layer("t2_pos", 1'b0);
      set_mem(16'h7FFF, 16'h8000, 16'h8000);
      push(neg_sat, neg_sat);
      run_layer("t2_neg", 1'b0);

      // floor behaviour and weight addressing
      set_mem(16'h0001, 16'h0080, 16'h0080);
      push(16'h0005, 16'h0005);
      run_layer("t3_small", 1'b0);
      set_mem(16'hFFFF, 16'h0001, 16'h0001);
      push(neg_one, neg_one);
      run_layer("t3_floor", 1'b0);
      set_mem(16'h0100, 16'h0100, 16'h0200);
      push(16'h0A00, 16'h1400);
      run_layer("t3_waddr", 1'b0);

      // back-pressure in OUT
      set_mem(16'h0100, 16'h0100, 16'h0100);
      push(16'h0A00, 16'h0A00);
      out_ready = 1'b0;
      pulse_start();
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      check("t4_reach_out", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_data", 32'(out_data), 32'h0A00);
         check("t4_hold_index", 32'(out_index), 32'd0);
         check("t4_hold_in_addr", 32'(in_addr), 32'd9);
         check("t4_hold_w_addr", 32'(w_addr), 32'd9);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("t4_next_valid", 32'(out_valid), 32'd0);
      check("t4_next_busy", 32'(busy), 32'd1);
      check("t4_next_in_addr", 32'(in_addr), 32'd0);
      check("t4_next_w_addr", 32'(w_addr), 32'd10);
      wait_done("t4", lat, dones);
      check("t4_done_count", 32'(dones), 32'd1);

      // start during RUN is ignored
      push(16'h0A00, 16'h0A00);
      pulse_start();
      repeat (3) tick();
      pulse_start();
      wait_done("t5a", lat, dones);
      check("t5a_latency", 32'(lat), 32'd7);
      check("t5a_done_count", 32'(dones), 32'd1);
      busy_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         if (busy) busy_cnt++;
         tick();
      end
      check("t5a_idle_after", 32'(busy_cnt), 32'd0);

      // start together with reset
      reset = 1'b0; start = 1'b1;
      tick();
      reset = 1'b1; start = 1'b0;
      check("t5b_busy", 32'(busy), 32'd0);
      tick();
      check("t5b_busy_after", 32'(busy), 32'd0);
      check("t5b_valid_after", 32'(out_valid), 32'd0);

      // reset in the middle of neuron 1
      exp_q.push_back({1'b0, 16'h0A00});
      pulse_start();
      n = 0;
      while (!(busy && !out_valid && out_index == 1'b1 && in_addr == 4'd4) && n < 100) begin tick(); n++; end
      check("t6_reach_i4", 32'(in_addr), 32'd4);
      reset = 1'b0;
      tick();
      check("t6_in_addr", 32'(in_addr), 32'd0);
      check("t6_w_addr", 32'(w_addr), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_out_data", 32'(out_data), 32'd0);
      check("t6_out_index", 32'(out_index), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      reset = 1'b1;
      tick();
      check("t6_no_done", 32'(done), 32'd0);
      push(16'h0A00, 16'h0A00);
      run_layer("t6_rerun", 1'b1);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
